// File: rtl/axi_chan_pkg.sv
// Shared types for the AXI-style VALID/READY channel blocks.
// Holds the receiver state encoding and default channel widths.
package axi_chan_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } rx_state_t;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_CNT_WIDTH = 16;

endpackage

// File: rtl/rx_channel_if.sv
// Bus-side and consumer-side handshake bundle of one receive channel.
// master = transmitter/consumer environment, slave = rx_channel.
interface rx_channel_if
    import axi_chan_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) ();

    logic                 VALID;
    logic                 READY;
    logic [WIDTH-1:0]     xDATA;
    logic                 rx_en;
    logic                 rx_valid;
    logic [WIDTH-1:0]     rx_data;
    logic                 rx_ready;
    logic [CNT_WIDTH-1:0] rx_count;
    logic                 proto_err;

    modport master (
        output VALID, xDATA, rx_en, rx_ready,
        input  READY, rx_valid, rx_data, rx_count, proto_err
    );

    modport slave (
        input  VALID, xDATA, rx_en, rx_ready,
        output READY, rx_valid, rx_data, rx_count, proto_err
    );

endinterface

// File: rtl/axi_vr_checker.sv
// Source-side VALID/data hold-rule monitor; usable on any VALID/READY channel.
// Once a beat is offered and stalled it must stay offered with stable data.
module axi_vr_checker #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             valid,
    input  logic             ready,
    input  logic [WIDTH-1:0] data,
    output logic             proto_err
);

    logic             armed_r;
    logic             prev_valid_r;
    logic             prev_ready_r;
    logic [WIDTH-1:0] prev_data_r;
    logic             err_r;
    logic             violation_s;

    // A stalled beat was withdrawn or its payload changed.
    always_comb begin
        violation_s = 1'b0;
        if (armed_r && prev_valid_r && !prev_ready_r) begin
            violation_s = !valid || (data != prev_data_r);
        end else begin
            violation_s = 1'b0;
        end
    end

    // History of the previous cycle and the sticky error flag.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            armed_r      <= 1'b0;
            prev_valid_r <= 1'b0;
            prev_ready_r <= 1'b0;
            prev_data_r  <= '0;
            err_r        <= 1'b0;
        end else begin
            armed_r      <= 1'b1;
            prev_valid_r <= valid;
            prev_ready_r <= ready;
            prev_data_r  <= data;
            if (violation_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign proto_err = err_r;

endmodule

// File: rtl/rx_channel.sv
// Receiving end of one VALID/READY channel: 2-entry skid buffer with registered
// READY, consumer handshake, accepted-beat counter and hold-rule checking.
module rx_channel
    import axi_chan_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic         ACLK,
    input  logic         ARESETn,
    rx_channel_if.slave  bus
);

    rx_state_t            state_r;
    logic [WIDTH-1:0]     out_r;
    logic [WIDTH-1:0]     skid_r;
    logic                 ready_r;
    logic                 valid_r;
    logic [CNT_WIDTH-1:0] count_r;
    logic                 in_hs_s;
    logic                 out_hs_s;
    logic                 err_s;

    // Handshake qualifiers for the bus side and the consumer side.
    always_comb begin
        in_hs_s  = bus.VALID && ready_r;
        out_hs_s = valid_r && bus.rx_ready;
    end

    // Buffer FSM; READY is dropped one cycle early so skid_r catches the in-flight beat.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_r <= EMPTY;
            out_r   <= '0;
            skid_r  <= '0;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                EMPTY: begin
                    ready_r <= bus.rx_en;
                    if (in_hs_s) begin
                        state_r <= BUSY;
                        out_r   <= bus.xDATA;
                        valid_r <= 1'b1;
                    end else begin
                        state_r <= EMPTY;
                        valid_r <= 1'b0;
                    end
                end
                BUSY: begin
                    if (in_hs_s && !out_hs_s) begin
                        state_r <= FULL;
                        skid_r  <= bus.xDATA;
                        ready_r <= 1'b0;
                    end else if (in_hs_s && out_hs_s) begin
                        out_r   <= bus.xDATA;
                        ready_r <= bus.rx_en;
                    end else if (out_hs_s) begin
                        state_r <= EMPTY;
                        valid_r <= 1'b0;
                        ready_r <= bus.rx_en;
                    end else begin
                        ready_r <= bus.rx_en;
                    end
                end
                FULL: begin
                    if (out_hs_s) begin
                        state_r <= BUSY;
                        out_r   <= skid_r;
                        ready_r <= bus.rx_en;
                    end else begin
                        ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                    valid_r <= 1'b0;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Accepted-beat counter, wraps naturally.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            count_r <= '0;
        end else if (in_hs_s) begin
            count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    axi_vr_checker #(.WIDTH(WIDTH)) u_checker (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .valid     (bus.VALID),
        .ready     (ready_r),
        .data      (bus.xDATA),
        .proto_err (err_s)
    );

    assign bus.READY     = ready_r;
    assign bus.rx_valid  = valid_r;
    assign bus.rx_data   = out_r;
    assign bus.rx_count  = count_r;
    assign bus.proto_err = err_s;

endmodule

// File: tb/tb_rx_channel.sv
// Scoreboard bench for rx_channel: a queue model of the buffered beats predicts
// READY, delivery order, count and hold-rule errors; a monitor pops and compares.
module tb_rx_channel;

    logic ACLK    = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    rx_channel_if #(.WIDTH(8), .CNT_WIDTH(16)) bus ();

    rx_channel #(.WIDTH(8), .CNT_WIDTH(16)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  q[$];
    logic [15:0] exp_count = 16'd0;
    logic        exp_err   = 1'b0;
    logic        exp_ready = 1'b0;
    logic [7:0]  last_data = 8'd0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [7:0]  pd = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare what the DUT presents this cycle, pop on consumer handshake.
    initial begin
        forever begin
            @(negedge ACLK);
            if (ARESETn) begin
                check("READY", {31'd0, bus.READY}, {31'd0, exp_ready});
                check("rx_valid", {31'd0, bus.rx_valid}, {31'd0, (q.size() != 0)});
                if (q.size() != 0) begin
                    check("rx_data", {24'd0, bus.rx_data}, {24'd0, q[0]});
                    last_data = q[0];
                    if (bus.rx_ready) void'(q.pop_front());
                end else begin
                    check("rx_data_hold", {24'd0, bus.rx_data}, {24'd0, last_data});
                end
                check("rx_count", {16'd0, bus.rx_count}, {16'd0, exp_count});
                check("proto_err", {31'd0, bus.proto_err}, {31'd0, exp_err});
            end
        end
    end

    // Predictor: decide what the coming edge accepts and update the model.
    initial begin
        forever begin
            @(negedge ACLK);
            #2;
            if (ARESETn) begin
                if (pv && !pr && (!bus.VALID || bus.xDATA != pd)) exp_err = 1'b1;
                pv = bus.VALID;
                pr = exp_ready;
                pd = bus.xDATA;
                if (bus.VALID && exp_ready) begin
                    q.push_back(bus.xDATA);
                    exp_count = exp_count + 16'd1;
                end
                exp_ready = bus.rx_en && (q.size() < 2);
            end
        end
    end

    task automatic clear_model();
        q.delete();
        exp_count = 16'd0;
        exp_err   = 1'b0;
        exp_ready = 1'b0;
        last_data = 8'd0;
        pv = 1'b0;
        pr = 1'b0;
        pd = 8'd0;
    endtask

    task automatic do_reset();
        @(posedge ACLK);
        #1;
        ARESETn = 1'b0;
        clear_model();
        #1;
        check("rst_READY", {31'd0, bus.READY}, 32'd0);
        check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("rst_rx_count", {16'd0, bus.rx_count}, 32'd0);
        check("rst_proto_err", {31'd0, bus.proto_err}, 32'd0);
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        #1;
        ARESETn = 1'b1;
    endtask

    task automatic send(input logic [7:0] d);
        @(posedge ACLK);
        #1;
        bus.VALID = 1'b1;
        bus.xDATA = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            #3;
            if (bus.READY) return;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: READY got 0 expected 1 for beat %0h", d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
            bus.VALID = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic rdy;
        bus.VALID    = 1'b0;
        bus.xDATA    = 8'd0;
        bus.rx_en    = 1'b1;
        bus.rx_ready = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("init_READY", {31'd0, bus.READY}, 32'd0);
        check("init_rx_data", {24'd0, bus.rx_data}, 32'd0);
        #1;
        ARESETn = 1'b1;

        // Single beat after reset, then 8 back-to-back beats.
        send(8'hA5);
        idle(3);
        for (int i = 1; i <= 8; i++) send(8'(i));
        idle(3);

        // Stalled consumer fills the skid entry, then drains in order.
        @(posedge ACLK); #1; bus.rx_ready = 1'b0;
        send(8'h03);
        send(8'h04);
        idle(3);
        @(posedge ACLK); #1; bus.rx_ready = 1'b1;
        idle(4);

        // rx_en drops on the cycle 0x55 is accepted; 0x66 waits until re-enabled.
        @(posedge ACLK); #1;
        bus.VALID = 1'b1; bus.xDATA = 8'h55; bus.rx_en = 1'b0;
        @(posedge ACLK); #1;
        bus.xDATA = 8'h66;
        repeat (5) @(posedge ACLK);
        #1; bus.rx_en = 1'b1;
        send(8'h66);
        idle(3);

        // Payload changed while stalled: sticky error until reset.
        @(posedge ACLK); #1; bus.rx_en = 1'b0;
        idle(2);
        @(posedge ACLK); #1; bus.VALID = 1'b1; bus.xDATA = 8'h11;
        @(posedge ACLK); #1; bus.xDATA = 8'h22;
        @(posedge ACLK); #1; bus.VALID = 1'b0;
        idle(3);
        @(posedge ACLK); #1; bus.rx_en = 1'b1;
        idle(3);
        do_reset();
        idle(3);

        // Reset while FULL discards both buffered beats.
        @(posedge ACLK); #1; bus.rx_ready = 1'b0;
        send(8'h77);
        send(8'h88);
        idle(2);
        do_reset();
        @(posedge ACLK); #1; bus.rx_ready = 1'b1;
        idle(5);

        // Randomised traffic from a rule-abiding transmitter.
        for (int n = 0; n < 400; n++) begin
            @(negedge ACLK);
            #3;
            rdy = bus.READY;
            @(posedge ACLK);
            #1;
            if (!(bus.VALID && !rdy)) begin
                bus.VALID = 1'($urandom_range(0, 1));
                bus.xDATA = 8'($urandom);
            end
            bus.rx_ready = ($urandom_range(0, 3) != 0);
            bus.rx_en    = ($urandom_range(0, 7) != 0);
        end
        @(negedge ACLK);
        #3;
        rdy = bus.READY;
        if (bus.VALID && !rdy) begin
            @(posedge ACLK); #1; bus.rx_en = 1'b1;
            send(bus.xDATA);
        end
        @(posedge ACLK); #1; bus.rx_ready = 1'b1; bus.rx_en = 1'b1;
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
